// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: range-checks per-instruction field bundles
// and packs legal ones into 32-bit words with sequential imem byte addresses.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [2:0]           format_i,
    input  logic [6:0]           opcode_i,
    input  logic [4:0]           rd_i,
    input  logic [4:0]           rs1_i,
    input  logic [4:0]           rs2_i,
    input  logic [2:0]           funct3_i,
    input  logic [6:0]           funct7_i,
    input  logic [31:0]          imm_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [31:0]          out_instr_o,
    output logic [ADDR_W-1:0]    out_addr_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);
    localparam logic [2:0] R_FORMAT = 3'd0;
    localparam logic [2:0] I_FORMAT = 3'd1;
    localparam logic [2:0] S_FORMAT = 3'd2;
    localparam logic [2:0] U_FORMAT = 3'd3;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(32'd4);

    logic                 s1_valid;
    logic                 s1_legal;
    logic [31:0]          s1_word;
    logic                 s2_valid;
    logic [31:0]          s2_word;
    logic [ADDR_W-1:0]    s2_addr;
    logic [ADDR_W-1:0]    next_addr;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_count;

    logic        flush;
    logic        s2_ready;
    logic        accept;
    logic        move;
    logic        shift_op;
    logic        imm12_ok;
    logic        imm_legal;
    logic        legal;
    logic [31:0] word;

    assign flush      = rst_i || clear_i;
    assign s2_ready   = !s2_valid || out_ready_i;
    assign in_ready_o = !flush && (!s1_valid || s2_ready);
    assign accept     = in_valid_i && in_ready_o;
    assign move       = s1_valid && s2_ready;

    assign shift_op = (funct3_i == 3'b001) || (funct3_i == 3'b101);
    // A value fits a signed 12-bit field when bits 31..11 are pure sign extension.
    assign imm12_ok = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);

    always_comb begin
        imm_legal = 1'b0;
        word      = '0;
        case (format_i)
            R_FORMAT: begin
                imm_legal = 1'b1;
                word      = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            I_FORMAT: begin
                if (shift_op) begin
                    imm_legal = (imm_i[31:5] == '0);
                    word      = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
                end else begin
                    imm_legal = imm12_ok;
                    word      = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                end
            end
            S_FORMAT: begin
                imm_legal = imm12_ok;
                word      = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            end
            U_FORMAT: begin
                imm_legal = (imm_i[11:0] == '0);
                word      = {imm_i[31:12], rd_i, opcode_i};
            end
            default: begin
                imm_legal = 1'b0;
                word      = '0;
            end
        endcase
    end

    assign legal = imm_legal && (opcode_i[1:0] == 2'b11);

    always_ff @(posedge clk_i) begin
        if (flush) begin
            s1_valid <= 1'b0;
            s1_legal <= 1'b0;
            s1_word  <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_legal <= legal;
            s1_word  <= word;
        end else if (move) begin
            s1_valid <= 1'b0;
        end
    end

    // Illegal words die at the S1->S2 boundary, so they consume no address.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            s2_valid  <= 1'b0;
            s2_word   <= '0;
            s2_addr   <= BASE;
            next_addr <= BASE;
            err       <= 1'b0;
            err_count <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid && s1_legal;
            if (move && s1_legal) begin
                s2_word   <= s1_word;
                s2_addr   <= next_addr;
                next_addr <= next_addr + STEP;
            end else if (move) begin
                err <= 1'b1;
                if (err_count != '1) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign out_valid_o = s2_valid;
    assign out_instr_o = s2_word;
    assign out_addr_o  = s2_addr;
    assign err_o       = err;
    assign err_count_o = err_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic
// scored against a field-arithmetic reference model.
module tb_instr_encoder;
    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    bundle_t     cur = '0;

    logic        in_ready, out_valid, err;
    logic [31:0] out_instr, out_addr;
    logic [7:0]  err_count;
    logic        w_in_ready, w_out_valid, w_err;
    logic [31:0] w_out_instr;
    logic [3:0]  w_out_addr;
    logic [7:0]  w_err_count;

    int total = 0;
    int bad = 0;
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];
    logic [35:0] w_got[$];
    logic [31:0] exp_addr = 32'h0;
    int          exp_err = 0;
    int          n_acc = 0;
    bit          rand_ready_en = 1'b0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .ERR_CNT_W(8)) u_dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .format_i(cur.fmt), .opcode_i(cur.opc), .rd_i(cur.rd), .rs1_i(cur.rs1), .rs2_i(cur.rs2),
        .funct3_i(cur.f3), .funct7_i(cur.f7), .imm_i(cur.imm),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_instr_o(out_instr),
        .out_addr_o(out_addr), .err_o(err), .err_count_o(err_count)
    );

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(32'hC), .ERR_CNT_W(8)) u_wrap (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .in_valid_i(in_valid), .in_ready_o(w_in_ready),
        .format_i(cur.fmt), .opcode_i(cur.opc), .rd_i(cur.rd), .rs1_i(cur.rs1), .rs2_i(cur.rs2),
        .funct3_i(cur.f3), .funct7_i(cur.f7), .imm_i(cur.imm),
        .out_valid_o(w_out_valid), .out_ready_i(out_ready), .out_instr_o(w_out_instr),
        .out_addr_o(w_out_addr), .err_o(w_err), .err_count_o(w_err_count)
    );

    function automatic bundle_t mk(input int fmt, input int opc, input int rd, input int rs1,
                                   input int rs2, input int f3, input int f7, input logic [31:0] imm);
        bundle_t b;
        b.fmt = 3'(fmt); b.opc = 7'(opc); b.rd = 5'(rd); b.rs1 = 5'(rs1); b.rs2 = 5'(rs2);
        b.f3 = 3'(f3); b.f7 = 7'(f7); b.imm = imm;
        return b;
    endfunction

    // Reference legality rules: format 0=R 1=I 2=S 3=U, anything else illegal.
    function automatic bit ref_legal(input bundle_t b);
        longint simm = longint'($signed(b.imm));
        longint uimm = longint'(b.imm);
        if ((int'(b.opc) % 4) != 3) return 1'b0;
        case (int'(b.fmt))
            0: return 1'b1;
            1: if (b.f3 == 3'd1 || b.f3 == 3'd5) return (simm >= 0 && simm <= 31);
               else return (simm >= -2048 && simm <= 2047);
            2: return (simm >= -2048 && simm <= 2047);
            3: return (uimm % 4096) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input bundle_t b);
        longint simm = longint'($signed(b.imm));
        longint f7 = longint'(b.f7), rs2 = longint'(b.rs2), rs1 = longint'(b.rs1);
        longint f3 = longint'(b.f3), rd = longint'(b.rd), opc = longint'(b.opc);
        longint w = 0;
        case (int'(b.fmt))
            0: w = f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + opc;
            1: if (b.f3 == 3'd1 || b.f3 == 3'd5)
                   w = f7 * 33554432 + (simm % 32) * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + opc;
               else
                   w = (simm & 4095) * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + opc;
            2: w = ((simm >>> 5) & 127) * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096
                   + (simm & 31) * 128 + opc;
            3: w = (longint'(b.imm) / 4096) * 4096 + rd * 128 + opc;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    function automatic bundle_t rand_bundle(input bit allow_illegal);
        bundle_t b;
        int edge_vals[6] = '{-2049, -2048, 2047, 2048, 31, 32};
        b.fmt = 3'($urandom_range(0, 3));
        b.opc = 7'($urandom) | 7'h03;
        b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
        b.f3 = 3'($urandom); b.f7 = 7'($urandom);
        case (int'(b.fmt))
            1: if (b.f3 == 3'd1 || b.f3 == 3'd5) b.imm = 32'($urandom_range(0, 31));
               else b.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            2: b.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            3: b.imm = $urandom & 32'hFFFF_F000;
            default: b.imm = $urandom;
        endcase
        if (allow_illegal) begin
            case ($urandom_range(0, 11))
                0: b.imm = $urandom;
                1, 2: b.imm = 32'(edge_vals[$urandom_range(0, 5)]);
                3: b.opc = 7'($urandom) & 7'h7E;
                4: b.fmt = 3'($urandom_range(4, 7));
                default: ;
            endcase
        end
        return b;
    endfunction

    // Reference model: scores each accepted bundle in acceptance order.
    always @(negedge clk) begin
        if (rst || clear) begin
            exp_q.delete();
            exp_addr = 32'h0;
            exp_err = 0;
        end else begin
            if (out_valid && out_ready) got_q.push_back({out_addr, out_instr});
            if (w_out_valid && out_ready) w_got.push_back({w_out_addr, w_out_instr});
            if (in_valid && in_ready) begin
                n_acc++;
                if (ref_legal(cur)) begin
                    exp_q.push_back({exp_addr, ref_word(cur)});
                    exp_addr = exp_addr + 32'd4;
                end else if (exp_err < 255) begin
                    exp_err++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input bundle_t b, output int waits);
        cur = b;
        in_valid = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 50) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        rand_ready_en = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        in_valid = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        got_q.delete();
        w_got.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        cur = mk(1, 'h13, 1, 2, 0, 0, 0, 32'hFFFF_FFFF);
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
        total++; if (out_addr !== 32'h0) begin bad++; $display("FAIL reset_out_addr: got %h want 0", out_addr); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (err_count !== 8'h0) begin bad++; $display("FAIL reset_err_count: got %h want 0", err_count); end
        total++; if (w_out_addr !== 4'hC) begin bad++; $display("FAIL reset_wrap_addr: got %h want c", w_out_addr); end
        repeat (3) @(posedge clk); #1;
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL reset_no_accept: got %0d words want 0", got_q.size()); end
    endtask

    task automatic test_addi();
        int waits;
        out_ready = 1'b1;
        send(mk(1, 'h13, 1, 2, 0, 0, 0, 32'hFFFF_FFFF), waits);
        in_valid = 1'b0;
        total++; if (waits != 0) begin bad++; $display("FAIL addi_accept: got %0d waits want 0", waits); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_latency_early: got %b want 0", out_valid); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_latency: got %b want 1", out_valid); end
        total++; if (out_instr !== 32'hFFF10093) begin bad++; $display("FAIL addi_word: got %h want fff10093", out_instr); end
        total++; if (out_addr !== 32'h0) begin bad++; $display("FAIL addi_addr: got %h want 0", out_addr); end
        drain();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL addi_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_store();
        int waits;
        send(mk(2, 'h23, 0, 2, 5, 2, 0, 32'd8), waits);
        drain();
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL sw_count: got %0d want 1", got_q.size()); end
        else begin
            total++; if (got_q[0] !== {32'h4, 32'h00512423}) begin bad++; $display("FAIL sw_word: got %h want 0000000400512423", got_q[0]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_lui_illegal();
        int waits;
        pulse_clear();
        out_ready = 1'b1;
        send(mk(3, 'h37, 3, 0, 0, 0, 0, 32'h12345000), waits);
        send(mk(3, 'h37, 3, 0, 0, 0, 0, 32'h12345001), waits);
        send(mk(1, 'h13, 4, 4, 0, 0, 0, 32'd5), waits);
        drain();
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL lui_count: got %0d want 2", got_q.size()); end
        else begin
            total++; if (got_q[0] !== {32'h0, 32'h123451B7}) begin bad++; $display("FAIL lui_word: got %h want 00000000123451b7", got_q[0]); end
            total++; if (got_q[1][63:32] !== 32'h4) begin bad++; $display("FAIL lui_no_gap: got %h want 4", got_q[1][63:32]); end
            total++; if (got_q[1] !== exp_q[1]) begin bad++; $display("FAIL lui_next: got %h want %h", got_q[1], exp_q[1]); end
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL lui_err: got %b want 1", err); end
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL lui_err_count: got %0d want 1", err_count); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_shift();
        int waits;
        pulse_clear();
        out_ready = 1'b1;
        send(mk(1, 'h13, 1, 1, 0, 5, 'h20, 32'd3), waits);
        send(mk(1, 'h13, 1, 1, 0, 5, 'h20, 32'd32), waits);
        drain();
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL srai_count: got %0d want 1", got_q.size()); end
        else begin
            total++; if (got_q[0][31:0] !== 32'h4030D093) begin bad++; $display("FAIL srai_word: got %h want 4030d093", got_q[0][31:0]); end
        end
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL srai_err_count: got %0d want 1", err_count); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_imm_bounds();
        int waits, n_legal;
        bundle_t tbl[13];
        bit      ok[13];
        tbl[0]  = mk(1, 'h13, 1, 2, 0, 0, 0, -32'sd2048); ok[0]  = 1;
        tbl[1]  = mk(1, 'h13, 1, 2, 0, 0, 0, 32'd2047);   ok[1]  = 1;
        tbl[2]  = mk(1, 'h13, 1, 2, 0, 0, 0, 32'd2048);   ok[2]  = 0;
        tbl[3]  = mk(1, 'h13, 1, 2, 0, 0, 0, -32'sd2049); ok[3]  = 0;
        tbl[4]  = mk(2, 'h23, 0, 2, 3, 2, 0, 32'd2047);   ok[4]  = 1;
        tbl[5]  = mk(2, 'h23, 0, 2, 3, 2, 0, -32'sd2049); ok[5]  = 0;
        tbl[6]  = mk(1, 'h13, 1, 2, 0, 1, 0, 32'd31);     ok[6]  = 1;
        tbl[7]  = mk(1, 'h13, 1, 2, 0, 1, 0, 32'd32);     ok[7]  = 0;
        tbl[8]  = mk(1, 'h13, 1, 2, 0, 5, 0, -32'sd1);    ok[8]  = 0;
        tbl[9]  = mk(3, 'h17, 1, 0, 0, 0, 0, 32'h1000);   ok[9]  = 1;
        tbl[10] = mk(3, 'h17, 1, 0, 0, 0, 0, 32'h800);    ok[10] = 0;
        tbl[11] = mk(0, 'h32, 1, 2, 3, 0, 0, 32'h0);      ok[11] = 0;
        tbl[12] = mk(4, 'h33, 1, 2, 3, 0, 0, 32'h0);      ok[12] = 0;
        pulse_clear();
        out_ready = 1'b1;
        n_legal = 0;
        foreach (tbl[i]) begin
            send(tbl[i], waits);
            if (ok[i]) n_legal++;
        end
        drain();
        total++; if (got_q.size() != n_legal) begin bad++; $display("FAIL bounds_count: got %0d want %0d", got_q.size(), n_legal); end
        total++; if (int'(err_count) != 13 - n_legal) begin bad++; $display("FAIL bounds_err_count: got %0d want %0d", err_count, 13 - n_legal); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bounds_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        int waits, acc0;
        logic [31:0] held_instr;
        bundle_t b[3];
        for (int i = 0; i < 3; i++) b[i] = rand_bundle(1'b0);
        pulse_clear();
        out_ready = 1'b0;
        acc0 = n_acc;
        send(b[0], waits);
        send(b[1], waits);
        cur = b[2];
        held_instr = ref_word(b[0]);
        repeat (4) begin
            @(negedge clk);
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
            total++; if (out_valid !== 1'b1 || out_instr !== held_instr || out_addr !== 32'h0) begin
                bad++; $display("FAIL bp_hold: got v=%b %h @%h want v=1 %h @0", out_valid, out_instr, out_addr, held_instr);
            end
            @(posedge clk); #1;
        end
        total++; if (n_acc - acc0 != 2) begin bad++; $display("FAIL bp_accepted: got %0d want 2", n_acc - acc0); end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got %b want 1", in_ready); end
        @(posedge clk); #1;
        drain();
        total++; if (got_q.size() != 3) begin bad++; $display("FAIL bp_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            total++; if (got_q[i] !== {32'(4 * i), ref_word(b[i])}) begin
                bad++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], {32'(4 * i), ref_word(b[i])});
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_wrap();
        int waits;
        logic [3:0] want[3] = '{4'hC, 4'h0, 4'h4};
        bundle_t b[3];
        for (int i = 0; i < 3; i++) b[i] = rand_bundle(1'b0);
        pulse_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(b[i], waits);
        drain();
        total++; if (w_got.size() != 3) begin bad++; $display("FAIL wrap_count: got %0d want 3", w_got.size()); end
        for (int i = 0; i < w_got.size() && i < 3; i++) begin
            total++; if (w_got[i] !== {want[i], ref_word(b[i])}) begin
                bad++; $display("FAIL wrap_word%0d: got %h want %h", i, w_got[i], {want[i], ref_word(b[i])});
            end
        end
        got_q.delete(); exp_q.delete(); w_got.delete();
    endtask

    task automatic test_clear();
        int waits;
        bundle_t e;
        pulse_clear();
        out_ready = 1'b1;
        send(mk(1, 'h13, 1, 1, 0, 1, 0, 32'd40), waits);
        drain();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL clear_pre_err: got %b want 1", err); end
        out_ready = 1'b0;
        send(rand_bundle(1'b0), waits);
        send(rand_bundle(1'b0), waits);
        cur = rand_bundle(1'b0);
        in_valid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL clear_in_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== 32'h0) begin
            bad++; $display("FAIL clear_out: got v=%b %h @%h want v=0 0 @0", out_valid, out_instr, out_addr);
        end
        total++; if (err !== 1'b0 || err_count !== 8'h0) begin bad++; $display("FAIL clear_err: got %b/%0d want 0/0", err, err_count); end
        got_q.delete();
        drain();
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL clear_flushed: got %0d words want 0", got_q.size()); end
        e = rand_bundle(1'b0);
        send(e, waits);
        drain();
        total++; if (got_q.size() != 1 || got_q[0] !== {32'h0, ref_word(e)}) begin
            bad++; $display("FAIL clear_restart: got %0d words first %h want 1 word %h", got_q.size(),
                            (got_q.size() > 0) ? got_q[0] : 64'h0, {32'h0, ref_word(e)});
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int waits, slow;
        pulse_clear();
        out_ready = 1'b1;
        slow = 0;
        for (int i = 0; i < 12; i++) begin
            send(rand_bundle(1'b0), waits);
            if (waits != 0) slow++;
        end
        drain();
        total++; if (slow != 0) begin bad++; $display("FAIL b2b_stalls: got %0d stalled sends want 0", slow); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int waits, timeouts;
        pulse_clear();
        timeouts = 0;
        rand_ready_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end else begin
                send(rand_bundle(1'b1), waits);
                if (waits > 50) timeouts++;
            end
        end
        drain();
        total++; if (timeouts != 0) begin bad++; $display("FAIL rand_timeout: got %0d timeouts want 0", timeouts); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL rand_err_count: got %0d want %0d", err_count, exp_err); end
        total++; if (err !== (exp_err != 0)) begin bad++; $display("FAIL rand_err: got %b want %b", err, exp_err != 0); end
        total++; if (w_err_count !== 8'(exp_err)) begin bad++; $display("FAIL rand_wrap_err_count: got %0d want %0d", w_err_count, exp_err); end
        got_q.delete(); exp_q.delete(); w_got.delete();
    endtask

    task automatic test_saturation();
        int waits;
        bundle_t b;
        pulse_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            b = rand_bundle(1'b0);
            b.opc = b.opc & 7'h7C;
            send(b, waits);
        end
        drain();
        total++; if (err_count !== 8'hFF) begin bad++; $display("FAIL sat_err_count: got %0d want 255", err_count); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL sat_err: got %b want 1", err); end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL sat_no_words: got %0d want 0", got_q.size()); end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addi();
        test_store();
        test_lui_illegal();
        test_shift();
        test_imm_bounds();
        test_backpressure();
        test_wrap();
        test_clear();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
